// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage: 32-step shift-add multiply or restoring
// divide, stalls ID/EX while busy. Optional macro MULDIV_EARLY_OUT_EN ends multiplies early.
module ex_muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] srcl,
   input  logic [WIDTH-1:0] rtdata,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

   state_t               state, state_nx;
   logic [CNT_W-1:0]     cnt;
   logic [1:0]           op_q;
   logic                 neg_a, neg_b, dz;
   logic [2*WIDTH-1:0]   acc, mcand;
   logic [WIDTH-1:0]     mplier;
   logic [WIDTH:0]       rem;
   logic [WIDTH-1:0]     quo, dvsr;
   logic [WIDTH-1:0]     mag_a, mag_b;
   logic [WIDTH+1:0]     diff;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quo_fix, rem_fix;
   logic                 early;

   always_comb begin
      mag_a = (op[0] && srcl[WIDTH-1])   ? -srcl   : srcl;
      mag_b = (op[0] && rtdata[WIDTH-1]) ? -rtdata : rtdata;
      // rem[WIDTH] is always 0 between steps, so {rem, q} is the shifted partial remainder
      diff  = {rem, quo[WIDTH-1]} - {2'b00, dvsr};
      prod_fix = (neg_a ^ neg_b) ? -acc : acc;
      quo_fix  = (neg_a ^ neg_b) ? -quo : quo;
      rem_fix  = neg_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
`ifdef MULDIV_EARLY_OUT_EN
      early = !op_q[1] && (mplier == '0);
`else
      early = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = BUSY;
         BUSY:    if (cnt == CNT_W'(WIDTH-1) || early) state_nx = FIX;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      stall = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         op_q   <= '0;
         neg_a  <= 1'b0;
         neg_b  <= 1'b0;
         dz     <= 1'b0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         rem    <= '0;
         quo    <= '0;
         dvsr   <= '0;
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               op_q   <= op;
               neg_a  <= op[0] & srcl[WIDTH-1];
               neg_b  <= op[0] & rtdata[WIDTH-1];
               dz     <= op[1] && (rtdata == '0);
               cnt    <= '0;
               acc    <= '0;
               mcand  <= {{WIDTH{1'b0}}, mag_a};
               mplier <= mag_b;
               rem    <= '0;
               quo    <= mag_a;
               dvsr   <= mag_b;
            end
            BUSY: begin
               cnt <= cnt + CNT_W'(1);
               if (!op_q[1]) begin
                  if (mplier[0]) acc <= acc + mcand;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
               end else if (!diff[WIDTH+1]) begin
                  rem <= diff[WIDTH:0];
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= {rem[WIDTH-1:0], quo[WIDTH-1]};
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end
            end
            FIX: begin
               done <= 1'b1;
               if (!op_q[1]) begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end else begin
                  // divide by zero: remainder already equals srcl after sign fix-up
                  hi <= rem_fix;
                  lo <= dz ? '1 : quo_fix;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed vectors push expected hi/lo and done cycle;
// a negedge monitor pops and compares on every done pulse.
module tb_ex_muldiv_unit;

   localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] srcl = '0, rtdata = '0;
   logic        stall, done;
   logic [31:0] hi, lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
      int          id;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;

   ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .srcl(srcl), .rtdata(rtdata),
      .stall(stall), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   // Multiply latency in edges from the start edge to the edge before done is seen
   function automatic int mul_lat(input logic [31:0] m);
`ifdef MULDIV_EARLY_OUT_EN
      int l;
      l = 2;
      for (int i = 0; i < 32; i++) if (m[i]) l = i + 3;
      return (l > 33) ? 33 : l;
`else
      return 33;
`endif
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst && done) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_done: hi=%h lo=%h at cyc %0d, want no done", hi, lo, cyc);
         end else begin
            e = sb.pop_front();
            if (hi !== e.hi || lo !== e.lo || cyc != e.cyc) begin
               miscompares++;
               $display("FAIL result_%0d: hi=%h lo=%h cyc=%0d, want hi=%h lo=%h cyc=%0d",
                        e.id, hi, lo, cyc, e.hi, e.lo, e.cyc);
            end
         end
      end
   end

   // Caller must be just after a negedge; returns #1 after the start edge
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] eh, input logic [31:0] el,
                        input int lat, input int id);
      exp_t e;
      start = 1'b1; op = o; srcl = a; rtdata = b;
      @(posedge clk); #1;
      start = 1'b0;
      if (push) begin
         e.hi = eh; e.lo = el; e.cyc = cyc + lat; e.id = id;
         sb.push_back(e);
      end
   endtask

   task automatic wait_drain(input int id);
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      if (sb.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_%0d: %0d results pending, want 0", id, sb.size());
         sb.delete();
      end
   endtask

   initial begin
      int n;
      bit seen;

      // reset then idle
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         vectors++;
         if ({stall, done, hi, lo} !== '0) begin
            miscompares++;
            $display("FAIL idle_%0d: stall=%b done=%b hi=%h lo=%h, want all 0", i, stall, done, hi, lo);
         end
      end

      // MULTU max*max with stall-length and single-cycle done checks
      issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001,
            mul_lat(32'hFFFF_FFFF), 1);
      n = 0; seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) begin seen = 1; break; end
         if (stall) n++;
      end
      vectors++;
      if (!seen || n != 33) begin
         miscompares++;
         $display("FAIL stall_len: stall cycles=%0d done_seen=%0b, want 33 and 1", n, seen);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || stall !== 1'b0) begin
         miscompares++;
         $display("FAIL done_pulse: done=%b stall=%b, want 0 0", done, stall);
      end

      issue(MULT, 32'hFFFF_FFFD, 32'd7, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, mul_lat(32'd7), 2);
      wait_drain(2);
      issue(DIV, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 3);
      wait_drain(3);
      issue(DIVU, 32'd100, 32'd0, 1, 32'd100, 32'hFFFF_FFFF, 33, 4);
      wait_drain(4);
      issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, 32'h8000_0000, 33, 5);
      wait_drain(5);
      issue(MULT, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 32'h0000_0000,
            mul_lat(32'h8000_0000), 6);
      wait_drain(6);
      issue(DIV, 32'hFFFF_FFF9, 32'd0, 1, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 33, 7);
      wait_drain(7);
      issue(DIVU, 32'd1000, 32'd7, 1, 32'd6, 32'd142, 33, 8);
      wait_drain(8);
      issue(MULTU, 32'd9, 32'd3, 1, 32'd0, 32'd27, mul_lat(32'd3), 9);
      wait_drain(9);

      // abort: second start ignored in BUSY, reset mid-run gives no done and clears hi/lo
      issue(MULTU, 32'd3, 32'd5, 0, '0, '0, 0, 10);
      repeat (5) @(negedge clk);
      start = 1'b1; op = DIVU; srcl = 32'd50; rtdata = 32'd3;
      @(negedge clk) start = 1'b0;
      repeat (14) @(negedge clk);
      rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      vectors++;
      if ({stall, done, hi, lo} !== '0) begin
         miscompares++;
         $display("FAIL abort: stall=%b done=%b hi=%h lo=%h, want all 0", stall, done, hi, lo);
      end
      repeat (40) @(negedge clk);
      vectors++;
      if (stall !== 1'b0 || hi !== '0 || lo !== '0) begin
         miscompares++;
         $display("FAIL abort_quiet: stall=%b hi=%h lo=%h, want 0 0 0", stall, hi, lo);
      end

      // back-to-back: DIVU starts in the done cycle of MULTU
      issue(MULTU, 32'd6, 32'd7, 1, 32'd0, 32'd42, mul_lat(32'd7), 11);
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) begin seen = 1; break; end
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL b2b_wait: done never seen, want done");
      end
      issue(DIVU, 32'd17, 32'd5, 1, 32'd2, 32'd3, 33, 12);
      wait_drain(12);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
